// File: rtl/dmd_packet_loader_if.sv
// Bus bundle between the packet loader and its neighbours: UART receive
// strobes, UART transmit handshake, frame-buffer write port and status.
interface dmd_packet_loader_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_eop;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_wdata;
    logic              frame_swap;
    logic              busy;
    logic [7:0]        err_count;

    // Loader side: consumes receive/transmit-status, drives everything else.
    modport slave (
        input  rx_data, rx_valid, rx_eop, tx_busy,
        output tx_data, tx_start, fb_we, fb_addr, fb_wdata,
               frame_swap, busy, err_count
    );

    // Environment side: UART model, frame buffer, status observer.
    modport master (
        output rx_data, rx_valid, rx_eop, tx_busy,
        input  tx_data, tx_start, fb_we, fb_addr, fb_wdata,
               frame_swap, busy, err_count
    );
endinterface

// File: rtl/dmd_packet_loader.sv
// Byte-stream command parser: validates framed packets from the UART,
// streams pixel payloads into frame-buffer RAM, requests buffer swaps and
// answers every completed packet with an ACK or NAK byte.
module dmd_packet_loader #(
    parameter int         ADDR_W   = 12,
    parameter logic [7:0] ACK_BYTE = 8'h06,
    parameter logic [7:0] NAK_BYTE = 8'h15
) (
    input  logic               clk,
    input  logic               rst,
    dmd_packet_loader_if.slave bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_ADDR_H  = 3'd2;
    localparam logic [2:0] S_ADDR_L  = 3'd3;
    localparam logic [2:0] S_LEN     = 3'd4;
    localparam logic [2:0] S_PAYLOAD = 3'd5;
    localparam logic [2:0] S_CSUM    = 3'd6;
    localparam logic [2:0] S_RESP    = 3'd7;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_SWAP  = 8'h02;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic              r_busy;
    logic [7:0]        r_cmd;
    logic [7:0]        r_addr_h;
    logic [ADDR_W-1:0] r_addr;
    logic [8:0]        r_count;
    logic [7:0]        r_csum;
    logic [7:0]        r_resp;
    logic [7:0]        r_err_count;
    logic              r_tx_start;
    logic [7:0]        r_tx_data;
    logic              r_fb_we;
    logic [ADDR_W-1:0] r_fb_addr;
    logic [7:0]        r_fb_wdata;
    logic              r_frame_swap;

    logic              w_in_packet;
    logic              w_abort;
    logic              w_byte;

    // Saturating increment for the error counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // An end-of-packet strobe always swallows a coincident byte; it only
    // aborts while a packet is partially received.
    assign w_in_packet = (r_state != S_IDLE) && (r_state != S_RESP);
    assign w_abort     = bus.rx_eop && w_in_packet;
    assign w_byte      = bus.rx_valid && !bus.rx_eop;

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        if (w_abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_byte && bus.rx_data == SYNC_BYTE) w_next_state = S_CMD;
                S_CMD: begin
                    if (w_byte) begin
                        if (bus.rx_data == CMD_WRITE)     w_next_state = S_ADDR_H;
                        else if (bus.rx_data == CMD_SWAP) w_next_state = S_CSUM;
                        else                              w_next_state = S_RESP;
                    end
                end
                S_ADDR_H:  if (w_byte) w_next_state = S_ADDR_L;
                S_ADDR_L:  if (w_byte) w_next_state = S_LEN;
                S_LEN:     if (w_byte) w_next_state = S_PAYLOAD;
                S_PAYLOAD: if (w_byte && r_count == 9'd1) w_next_state = S_CSUM;
                S_CSUM:    if (w_byte) w_next_state = S_RESP;
                // Leave RESP the cycle after tx_start so busy covers the pulse.
                S_RESP:    if (r_tx_start) w_next_state = S_IDLE;
                default:   w_next_state = S_IDLE;
            endcase
        end
    end

    // State register and registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
        end
    end

    // Packet capture, checksum, frame-buffer writes, response and errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd        <= 8'h00;
            r_addr_h     <= 8'h00;
            r_addr       <= '0;
            r_count      <= 9'd0;
            r_csum       <= 8'h00;
            r_resp       <= 8'h00;
            r_err_count  <= 8'h00;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_wdata   <= 8'h00;
            r_frame_swap <= 1'b0;
        end else begin
            r_fb_we      <= 1'b0;
            r_frame_swap <= 1'b0;
            r_tx_start   <= 1'b0;
            if (w_abort) begin
                r_err_count <= sat_inc(r_err_count);
            end else begin
                case (r_state)
                    S_CMD: begin
                        if (w_byte) begin
                            r_cmd  <= bus.rx_data;
                            r_csum <= bus.rx_data;
                            if (bus.rx_data != CMD_WRITE && bus.rx_data != CMD_SWAP) begin
                                r_resp      <= NAK_BYTE;
                                r_err_count <= sat_inc(r_err_count);
                            end
                        end
                    end
                    S_ADDR_H: begin
                        if (w_byte) begin
                            r_addr_h <= bus.rx_data;
                            r_csum   <= r_csum ^ bus.rx_data;
                        end
                    end
                    S_ADDR_L: begin
                        if (w_byte) begin
                            r_addr <= ADDR_W'({r_addr_h, bus.rx_data});
                            r_csum <= r_csum ^ bus.rx_data;
                        end
                    end
                    S_LEN: begin
                        if (w_byte) begin
                            r_count <= (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
                            r_csum  <= r_csum ^ bus.rx_data;
                        end
                    end
                    S_PAYLOAD: begin
                        if (w_byte) begin
                            r_fb_we    <= 1'b1;
                            r_fb_addr  <= r_addr;
                            r_fb_wdata <= bus.rx_data;
                            r_addr     <= r_addr + 1'b1;
                            r_count    <= r_count - 9'd1;
                            r_csum     <= r_csum ^ bus.rx_data;
                        end
                    end
                    S_CSUM: begin
                        if (w_byte) begin
                            if (bus.rx_data == r_csum) begin
                                r_resp       <= ACK_BYTE;
                                r_frame_swap <= (r_cmd == CMD_SWAP);
                            end else begin
                                r_resp      <= NAK_BYTE;
                                r_err_count <= sat_inc(r_err_count);
                            end
                        end
                    end
                    S_RESP: begin
                        if (!r_tx_start && !bus.tx_busy) begin
                            r_tx_start <= 1'b1;
                            r_tx_data  <= r_resp;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.tx_data    = r_tx_data;
    assign bus.tx_start   = r_tx_start;
    assign bus.fb_we      = r_fb_we;
    assign bus.fb_addr    = r_fb_addr;
    assign bus.fb_wdata   = r_fb_wdata;
    assign bus.frame_swap = r_frame_swap;
    assign bus.busy       = r_busy;
    assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_dmd_packet_loader.sv
// Directed testbench for dmd_packet_loader.
module tb_dmd_packet_loader;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    dmd_packet_loader_if #(.ADDR_W(12)) bus ();

    dmd_packet_loader #(.ADDR_W(12), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed write / response / swap history.
    logic [11:0] wq_addr[$];
    logic [7:0]  wq_data[$];
    int          tx_cnt;
    int          swap_cnt;
    int          tx_while_busy;

    always @(negedge clk) begin
        if (bus.fb_we) begin
            wq_addr.push_back(bus.fb_addr);
            wq_data.push_back(bus.fb_wdata);
        end
        if (bus.tx_start) begin
            tx_cnt = tx_cnt + 1;
            if (bus.tx_busy) tx_while_busy = tx_while_busy + 1;
        end
        if (bus.frame_swap) swap_cnt = swap_cnt + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for tx_start; a timeout counts as a failed check.
    task automatic wait_tx(input logic [7:0] exp, input string name);
        logic got;
        logic [7:0] d;
        got = 1'b0;
        d = 8'h00;
        for (int i = 0; i < 300; i++) begin
            if (bus.tx_start) begin
                got = 1'b1;
                d = bus.tx_data;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: tx_start never seen, expected data %02h", name, exp);
        end else if (d !== exp) begin
            errors++;
            $display("FAIL %s: tx_data=%02h expected %02h", name, d, exp);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_cycles(3);
        checks++;
        if ({bus.tx_start, bus.tx_data, bus.fb_we, bus.fb_addr, bus.fb_wdata,
             bus.frame_swap, bus.busy, bus.err_count} !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs: tx_start=%b tx_data=%02h fb_we=%b fb_addr=%03h fb_wdata=%02h swap=%b busy=%b err=%02h expected all zero",
                     bus.tx_start, bus.tx_data, bus.fb_we, bus.fb_addr, bus.fb_wdata,
                     bus.frame_swap, bus.busy, bus.err_count);
        end
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_write();
        wq_addr.delete();
        wq_data.delete();
        send_byte(8'hA5);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL busy_rise: busy=%b expected 1", bus.busy);
        end
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
        send_byte(8'h11);
        checks++;
        if ({bus.fb_we, bus.fb_addr, bus.fb_wdata} !== {1'b1, 12'h010, 8'h11}) begin
            errors++;
            $display("FAIL write_latency: we=%b addr=%03h data=%02h expected 1 010 11",
                     bus.fb_we, bus.fb_addr, bus.fb_wdata);
        end
        send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h12);
        checks++;
        if (bus.tx_start !== 1'b0) begin
            errors++; $display("FAIL tx_early: tx_start=%b at T+1 expected 0", bus.tx_start);
        end
        idle_cycles(1);
        checks++;
        if ({bus.tx_start, bus.tx_data, bus.busy} !== {1'b1, 8'h06, 1'b1}) begin
            errors++;
            $display("FAIL good_ack: tx_start=%b tx_data=%02h busy=%b expected 1 06 1",
                     bus.tx_start, bus.tx_data, bus.busy);
        end
        idle_cycles(1);
        checks++;
        if ({bus.tx_start, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL busy_fall: tx_start=%b busy=%b expected 0 0", bus.tx_start, bus.busy);
        end
        checks++;
        if (wq_addr.size() != 3 || wq_addr[0] !== 12'h010 || wq_addr[1] !== 12'h011 ||
            wq_addr[2] !== 12'h012 || wq_data[0] !== 8'h11 || wq_data[1] !== 8'h22 ||
            wq_data[2] !== 8'h33) begin
            errors++;
            $display("FAIL good_writes: count=%0d expected 3 at 010/011/012 with 11/22/33",
                     wq_addr.size());
        end
        checks++;
        if (bus.err_count !== 8'h00) begin
            errors++; $display("FAIL good_err: err_count=%02h expected 00", bus.err_count);
        end
    endtask

    task automatic test_wrap_len0();
        int bad_data;
        wq_addr.delete();
        wq_data.delete();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h0F); send_byte(8'hFF); send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'h5A);
        send_byte(8'hF1);
        wait_tx(8'h06, "wrap_ack");
        checks++;
        if (wq_addr.size() != 256) begin
            errors++; $display("FAIL wrap_count: writes=%0d expected 256", wq_addr.size());
        end else begin
            checks++;
            if (wq_addr[0] !== 12'hFFF || wq_addr[1] !== 12'h000 || wq_addr[255] !== 12'h0FE) begin
                errors++;
                $display("FAIL wrap_addr: first=%03h second=%03h last=%03h expected FFF 000 0FE",
                         wq_addr[0], wq_addr[1], wq_addr[255]);
            end
            bad_data = 0;
            for (int i = 0; i < 256; i++) if (wq_data[i] !== 8'h5A) bad_data++;
            checks++;
            if (bad_data != 0) begin
                errors++; $display("FAIL wrap_data: %0d bytes differ from 5A expected 0", bad_data);
            end
        end
    endtask

    task automatic test_swap();
        int s0;
        s0 = swap_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h02);
        checks++;
        if (bus.frame_swap !== 1'b1) begin
            errors++; $display("FAIL swap_pulse: frame_swap=%b expected 1", bus.frame_swap);
        end
        wait_tx(8'h06, "swap_ack");
        checks++;
        if (swap_cnt - s0 != 1) begin
            errors++; $display("FAIL swap_once: pulses=%0d expected 1", swap_cnt - s0);
        end
        s0 = swap_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h03);
        wait_tx(8'h15, "swap_bad_nak");
        checks++;
        if (swap_cnt != s0 || bus.err_count !== 8'h01) begin
            errors++;
            $display("FAIL swap_bad: pulses=%0d err_count=%02h expected 0 01",
                     swap_cnt - s0, bus.err_count);
        end
    endtask

    task automatic test_bad_cmd();
        int s0;
        send_byte(8'h55);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL idle_discard: busy=%b expected 0", bus.busy);
        end
        send_byte(8'hA5); send_byte(8'h7E);
        wait_tx(8'h15, "bad_cmd_nak");
        checks++;
        if (bus.err_count !== 8'h02) begin
            errors++; $display("FAIL bad_cmd_err: err_count=%02h expected 02", bus.err_count);
        end
        s0 = swap_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h02);
        wait_tx(8'h06, "after_bad_ack");
        checks++;
        if (swap_cnt - s0 != 1) begin
            errors++; $display("FAIL after_bad_swap: pulses=%0d expected 1", swap_cnt - s0);
        end
    endtask

    task automatic test_abort();
        int t0;
        t0 = tx_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
        bus.rx_eop = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_eop = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL abort_idle: busy=%b expected 0", bus.busy);
        end
        idle_cycles(10);
        checks++;
        if (tx_cnt != t0 || bus.err_count !== 8'h03) begin
            errors++;
            $display("FAIL abort_resp: tx_pulses=%0d err_count=%02h expected 0 03",
                     tx_cnt - t0, bus.err_count);
        end
        // A sync byte coinciding with rx_eop is discarded.
        bus.rx_data = 8'hA5; bus.rx_valid = 1'b1; bus.rx_eop = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0; bus.rx_eop = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.err_count !== 8'h03) begin
            errors++;
            $display("FAIL eop_wins: busy=%b err_count=%02h expected 0 03", bus.busy, bus.err_count);
        end
    endtask

    task automatic test_backpressure();
        int t0;
        int early;
        t0 = tx_cnt;
        early = 0;
        bus.tx_busy = 1'b1;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h02);
        for (int i = 0; i < 97; i++) begin
            @(posedge clk);
            #1;
            if (bus.tx_start) early++;
        end
        checks++;
        if (early != 0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: tx_start_while_busy=%0d busy=%b expected 0 1", early, bus.busy);
        end
        bus.tx_busy = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.tx_start, bus.tx_data} !== {1'b1, 8'h06}) begin
            errors++;
            $display("FAIL bp_release: tx_start=%b tx_data=%02h expected 1 06", bus.tx_start, bus.tx_data);
        end
        idle_cycles(10);
        checks++;
        if (tx_cnt - t0 != 1 || tx_while_busy != 0) begin
            errors++;
            $display("FAIL bp_once: pulses=%0d while_busy=%0d expected 1 0", tx_cnt - t0, tx_while_busy);
        end
    endtask

    task automatic test_reset_mid();
        wq_addr.delete();
        wq_data.delete();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.fb_we, bus.tx_start, bus.busy, bus.err_count, bus.fb_addr, bus.fb_wdata} !== 30'd0) begin
            errors++;
            $display("FAIL async_reset: fb_we=%b tx_start=%b busy=%b err=%02h addr=%03h data=%02h expected all zero",
                     bus.fb_we, bus.tx_start, bus.busy, bus.err_count, bus.fb_addr, bus.fb_wdata);
        end
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        wq_addr.delete();
        wq_data.delete();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h20); send_byte(8'h01);
        send_byte(8'h77); send_byte(8'h57);
        wait_tx(8'h06, "post_reset_ack");
        checks++;
        if (wq_addr.size() != 1 || wq_addr[0] !== 12'h020 || wq_data[0] !== 8'h77) begin
            errors++;
            $display("FAIL post_reset_write: writes=%0d expected 1 at 020 with 77", wq_addr.size());
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        tx_cnt = 0;
        swap_cnt = 0;
        tx_while_busy = 0;
        rst = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_eop = 1'b0;
        bus.tx_busy = 1'b0;
        #2;
        test_reset();
        test_good_write();
        test_wrap_len0();
        test_swap();
        test_bad_cmd();
        test_abort();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
